// File: rtl/spmmio_bus_pkg.sv
// spmmio_pkg -- shared definitions for the service-processor MMIO interconnect.
//   spmmio_state_e : transfer FSM states (IDLE, WAIT, RESP)
//   SLOT_*         : fixed slot numbers decoded from adr_i[0:7]
//   errlog_word    : packs the error-log read word
//                    {valid, 1'b0, we, 5'b0, adr[0:23]}
package spmmio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } spmmio_state_e;

   localparam logic [7:0] SLOT_MISC   = 8'h00;
   localparam logic [7:0] SLOT_SDCARD = 8'h01;
   localparam logic [7:0] SLOT_ERRLOG = 8'hFF;

   function automatic logic [31:0] errlog_word(input logic        valid,
                                                input logic        we,
                                                input logic [23:0] adr);
      return {valid, 1'b0, we, 5'b00000, adr};
   endfunction

endpackage

// File: rtl/spmmio_bus_timeout.sv
// spmmio_bus_timeout -- per-transfer wait-state counter.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : force the count to zero (held while the FSM is outside WAIT)
//   en         : count one cycle (asserted in WAIT)
//   expired    : registered flag, high while the count equals TIMEOUT-1,
//                i.e. during the TIMEOUT-th consecutive enabled cycle
module spmmio_bus_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nx_s;
   logic          expired_r;

   // Next count: clear wins, then saturating increment.
   always_comb begin
      count_nx_s = count_r;
      if (clr) begin
         count_nx_s = {CW{1'b0}};
      end else if (en && (count_r != SAT)) begin
         count_nx_s = count_r + CW'(1'b1);
      end else begin
         count_nx_s = count_r;
      end
   end

   // Count register; expired is derived from the next count so it is
   // already registered when the count reaches TIMEOUT-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r   <= {CW{1'b0}};
         expired_r <= 1'b0;
      end else begin
         count_r   <= count_nx_s;
         expired_r <= (count_nx_s == LAST);
      end
   end

   assign expired = expired_r;

endmodule

// File: rtl/spmmio_bus.sv
// spmmio_bus -- Wishbone-style slave port fanned out to NUM_SLAVES
// peripheral channels selected by adr_i[0:7]; each transfer runs through
// an IDLE -> WAIT -> RESP state machine with a wait-state timeout.
//
// Parameters: NUM_SLAVES (1..16), TIMEOUT (>= 2), UNMAPPED_ERR (1: err, 0: ack)
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   adr_i[0:23]        word address; [0:7] slot, [18:21] register offset
//   cyc_i, stb_i, we_i Wishbone cycle / strobe / write enable
//   sel_i, dat_i       byte lanes, write data
//   ack_o, err_o       one-cycle registered response (mutually exclusive)
//   dat_o              registered read data, valid with ack_o
//   s_cs_o             one-hot channel select, held for the whole WAIT phase
//   s_adr_o, s_we_o, s_sel_o, s_dat_o  registered request copies
//   s_dat_i            channel n read data at [32n +: 32]
//   s_ack_i            channel completion (held or pulsed)
//
// Optional build macro SPMMIO_BUS_ERRLOG_EN: slot 8'hFF becomes an internal
// error log (read: last error word; write: clear valid). Without it slot
// 8'hFF is an ordinary unmapped slot and no log registers exist.
module spmmio_bus
   import spmmio_pkg::*;
#(
   parameter int NUM_SLAVES   = 2,
   parameter int TIMEOUT      = 255,
   parameter int UNMAPPED_ERR = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [0:23]               adr_i,
   input  logic                      cyc_i,
   input  logic                      stb_i,
   input  logic                      we_i,
   input  logic [0:3]                sel_i,
   input  logic [0:31]               dat_i,
   output logic                      ack_o,
   output logic                      err_o,
   output logic [0:31]               dat_o,
   output logic [0:NUM_SLAVES-1]     s_cs_o,
   output logic [0:3]                s_adr_o,
   output logic                      s_we_o,
   output logic [0:3]                s_sel_o,
   output logic [0:31]               s_dat_o,
   input  logic [0:32*NUM_SLAVES-1]  s_dat_i,
   input  logic [0:NUM_SLAVES-1]     s_ack_i
);

   spmmio_state_e         state_r;
   spmmio_state_e         state_nx_s;
   logic                  req_s;
   logic [7:0]            slot_s;
   logic [0:NUM_SLAVES-1] cs_dec_s;
   logic                  mapped_s;
   logic                  is_log_s;
   logic [0:31]           log_word_s;
   logic                  sel_ack_s;
   logic [0:31]           sel_dat_s;
   logic                  expired_s;
   logic                  to_clr_s;
   logic                  to_en_s;
   logic                  ack_r;
   logic                  ack_nx_s;
   logic                  err_r;
   logic                  err_nx_s;
   logic [0:31]           dat_r;
   logic [0:31]           dat_nx_s;
   logic [0:NUM_SLAVES-1] cs_r;
   logic [0:NUM_SLAVES-1] cs_nx_s;
   logic [0:3]            s_adr_r;
   logic                  s_we_r;
   logic [0:3]            s_sel_r;
   logic [0:31]           s_dat_r;
   logic                  unused_s;

   // A new request is only accepted in IDLE; RESP always returns to IDLE
   // first, so a strobe still high across the ack edge is never re-issued.
   assign req_s  = (state_r == IDLE) && cyc_i && stb_i;
   assign slot_s = adr_i[0:7];

   // Address bits between the slot field and the register offset are not decoded.
   assign unused_s = ^{adr_i[8:17], adr_i[22:23]};

   // Slot decode of the incoming address into a one-hot channel select.
   always_comb begin
      cs_dec_s = '0;
      for (int n = 0; n < NUM_SLAVES; n++) begin
         cs_dec_s[n] = (slot_s == 8'(n));
      end
   end

   assign mapped_s = |cs_dec_s;

   // Completion and read data from the selected channel only; other
   // channels are masked out by the held one-hot select.
   always_comb begin
      sel_ack_s = |(s_ack_i & cs_r);
      sel_dat_s = 32'h0000_0000;
      for (int n = 0; n < NUM_SLAVES; n++) begin
         sel_dat_s = sel_dat_s | ({32{cs_r[n]}} & s_dat_i[32*n +: 32]);
      end
   end

   assign to_clr_s = (state_r != WAIT);
   assign to_en_s  = (state_r == WAIT);

   spmmio_bus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (to_clr_s),
      .en      (to_en_s),
      .expired (expired_s)
   );

`ifdef SPMMIO_BUS_ERRLOG_EN
   logic        log_valid_r;
   logic        log_we_r;
   logic [0:23] log_adr_r;
   logic [0:23] req_adr_r;

   assign is_log_s   = (slot_s == SLOT_ERRLOG);
   assign log_word_s = errlog_word(log_valid_r, log_we_r, log_adr_r);

   // Error log: every err_o transfer overwrites it, a write to the log slot clears valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         log_valid_r <= 1'b0;
         log_we_r    <= 1'b0;
         log_adr_r   <= 24'h00_0000;
         req_adr_r   <= 24'h00_0000;
      end else begin
         if (req_s) begin
            req_adr_r <= adr_i;
         end else begin
            req_adr_r <= req_adr_r;
         end
         if (err_nx_s) begin
            log_valid_r <= 1'b1;
            // Unmapped errors are raised straight from IDLE, timeouts from WAIT.
            if (state_r == IDLE) begin
               log_we_r  <= we_i;
               log_adr_r <= adr_i;
            end else begin
               log_we_r  <= s_we_r;
               log_adr_r <= req_adr_r;
            end
         end else if (req_s && is_log_s && we_i) begin
            log_valid_r <= 1'b0;
         end else begin
            log_valid_r <= log_valid_r;
         end
      end
   end
`else
   assign is_log_s   = 1'b0;
   assign log_word_s = 32'h0000_0000;
`endif

   // Transfer FSM next state plus the response/select values to register.
   always_comb begin
      state_nx_s = state_r;
      ack_nx_s   = 1'b0;
      err_nx_s   = 1'b0;
      dat_nx_s   = 32'h0000_0000;
      cs_nx_s    = cs_r;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               if (is_log_s) begin
                  state_nx_s = RESP;
                  ack_nx_s   = 1'b1;
                  dat_nx_s   = we_i ? 32'h0000_0000 : log_word_s;
                  cs_nx_s    = '0;
               end else if (mapped_s) begin
                  state_nx_s = WAIT;
                  cs_nx_s    = cs_dec_s;
               end else begin
                  state_nx_s = RESP;
                  ack_nx_s   = (UNMAPPED_ERR == 0);
                  err_nx_s   = (UNMAPPED_ERR != 0);
                  cs_nx_s    = '0;
               end
            end else begin
               state_nx_s = IDLE;
               cs_nx_s    = '0;
            end
         end
         WAIT: begin
            // Abort beats completion; completion beats timeout.
            if (!cyc_i) begin
               state_nx_s = IDLE;
               cs_nx_s    = '0;
            end else if (sel_ack_s) begin
               state_nx_s = RESP;
               ack_nx_s   = 1'b1;
               dat_nx_s   = s_we_r ? 32'h0000_0000 : sel_dat_s;
               cs_nx_s    = '0;
            end else if (expired_s) begin
               state_nx_s = RESP;
               err_nx_s   = 1'b1;
               cs_nx_s    = '0;
            end else begin
               state_nx_s = WAIT;
               cs_nx_s    = cs_r;
            end
         end
         RESP: begin
            state_nx_s = IDLE;
            cs_nx_s    = '0;
         end
         default: begin
            state_nx_s = IDLE;
            cs_nx_s    = '0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Registered response and channel select.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_r <= 1'b0;
         err_r <= 1'b0;
         dat_r <= 32'h0000_0000;
         cs_r  <= '0;
      end else begin
         ack_r <= ack_nx_s;
         err_r <= err_nx_s;
         dat_r <= dat_nx_s;
         cs_r  <= cs_nx_s;
      end
   end

   // Request copies presented to the peripherals, loaded on acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_adr_r <= 4'h0;
         s_we_r  <= 1'b0;
         s_sel_r <= 4'h0;
         s_dat_r <= 32'h0000_0000;
      end else if (req_s) begin
         s_adr_r <= adr_i[18:21];
         s_we_r  <= we_i;
         s_sel_r <= sel_i;
         s_dat_r <= dat_i;
      end else begin
         s_adr_r <= s_adr_r;
         s_we_r  <= s_we_r;
         s_sel_r <= s_sel_r;
         s_dat_r <= s_dat_r;
      end
   end

   assign ack_o   = ack_r;
   assign err_o   = err_r;
   assign dat_o   = dat_r;
   assign s_cs_o  = cs_r;
   assign s_adr_o = s_adr_r;
   assign s_we_o  = s_we_r;
   assign s_sel_o = s_sel_r;
   assign s_dat_o = s_dat_r;

endmodule

// File: tb/tb_spmmio_bus.sv
// tb_spmmio_bus -- self-checking bench for spmmio_bus (NUM_SLAVES=2,
// TIMEOUT=16). A second instance with UNMAPPED_ERR=0 shares all inputs.
// Expected responses are queued when a transfer is issued and popped when
// the DUT answers.
`timescale 1ns/1ps
module tb_spmmio_bus;

   localparam int NS    = 2;
   localparam int TO    = 16;
   localparam int K_ACK = 1;
   localparam int K_ERR = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [0:23]       adr_i;
   logic              cyc_i, stb_i, we_i;
   logic [0:3]        sel_i;
   logic [0:31]       dat_i;
   logic [0:32*NS-1]  s_dat_i;
   logic [0:NS-1]     s_ack_i;

   logic              ack_o, err_o, s_we_o;
   logic [0:31]       dat_o, s_dat_o;
   logic [0:NS-1]     s_cs_o;
   logic [0:3]        s_adr_o, s_sel_o;

   logic              u_ack_o, u_err_o, u_s_we_o;
   logic [0:31]       u_dat_o, u_s_dat_o;
   logic [0:NS-1]     u_s_cs_o;
   logic [0:3]        u_s_adr_o, u_s_sel_o;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      int          kind;
      logic [0:31] dat;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   // snapshot of the second instance and response time at the last response
   logic        u_ack_snap, u_err_snap;
   logic [0:31] u_dat_snap;
   time         resp_t;

   spmmio_bus #(.NUM_SLAVES(NS), .TIMEOUT(TO), .UNMAPPED_ERR(1)) dut (
      .clk(clk), .reset(reset), .adr_i(adr_i), .cyc_i(cyc_i), .stb_i(stb_i),
      .we_i(we_i), .sel_i(sel_i), .dat_i(dat_i), .ack_o(ack_o), .err_o(err_o),
      .dat_o(dat_o), .s_cs_o(s_cs_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i));

   spmmio_bus #(.NUM_SLAVES(NS), .TIMEOUT(TO), .UNMAPPED_ERR(0)) dut_ua (
      .clk(clk), .reset(reset), .adr_i(adr_i), .cyc_i(cyc_i), .stb_i(stb_i),
      .we_i(we_i), .sel_i(sel_i), .dat_i(dat_i), .ack_o(u_ack_o), .err_o(u_err_o),
      .dat_o(u_dat_o), .s_cs_o(u_s_cs_o), .s_adr_o(u_s_adr_o), .s_we_o(u_s_we_o),
      .s_sel_o(u_s_sel_o), .s_dat_o(u_s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // One transfer: the slave for the selected channel acks after ack_wait
   // WAIT cycles (-1 = never); non-selected channels hold ack high throughout.
   task automatic xfer(input string name, input logic [7:0] slot, input logic [15:0] low,
                       input logic we, input logic [0:31] wdat, input logic [0:3] sel,
                       input int ack_wait, input logic [0:31] rdat,
                       input int kind, input logic [0:31] edat, input int lat);
      exp_t          e;
      logic [0:23]   adr;
      logic [0:NS-1] ecs;
      int            c;
      int            waits;
      bit            done;
      bit            cs_bad;
      adr = {slot, low};
      for (int n = 0; n < NS; n++) ecs[n] = (int'(slot) == n);
      e.kind = kind; e.dat = edat; e.lat = lat;
      sb_q.push_back(e);
      @(posedge clk); #1;
      adr_i = adr; cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; dat_i = wdat;
      s_dat_i = {NS{32'hA5A5_0F0F}};
      for (int n = 0; n < NS; n++) if (ecs[n]) s_dat_i[32*n +: 32] = rdat;
      s_ack_i = ~ecs;
      c = 0; waits = 0; done = 1'b0; cs_bad = 1'b0;
      while (!done && c < 64) begin
         @(posedge clk); #1;
         c++;
         if (ack_o || err_o) begin
            done = 1'b1;
            resp_t = $time;
            u_ack_snap = u_ack_o; u_err_snap = u_err_o; u_dat_snap = u_dat_o;
            e = sb_q.pop_front();
            checks++;
            if ((ack_o ? K_ACK : K_ERR) !== e.kind || (ack_o && err_o)) begin
               fails++;
               $display("FAIL %s resp: got ack=%0b err=%0b want kind %0d", name, ack_o, err_o, e.kind);
            end
            checks++;
            if (dat_o !== e.dat) begin
               fails++;
               $display("FAIL %s dat_o: got %h want %h", name, dat_o, e.dat);
            end
            checks++;
            if (c !== e.lat) begin
               fails++;
               $display("FAIL %s latency: got %0d want %0d", name, c, e.lat);
            end
            checks++;
            if (s_cs_o !== '0) begin
               fails++;
               $display("FAIL %s cs_in_resp: got %b want 0", name, s_cs_o);
            end
            if (waits > 0) begin
               checks++;
               if (cs_bad) begin
                  fails++;
                  $display("FAIL %s cs_held: select not one-hot %b for all WAIT cycles", name, ecs);
               end
            end
         end else begin
            if (s_cs_o !== ecs) cs_bad = 1'b1;
            if (c == 1) begin
               checks++;
               if ({s_adr_o, s_we_o, s_sel_o, s_dat_o} !== {adr[18:21], we, sel, wdat}) begin
                  fails++;
                  $display("FAIL %s req_copy: got %h/%b/%b/%h want %h/%b/%b/%h", name,
                           s_adr_o, s_we_o, s_sel_o, s_dat_o, adr[18:21], we, sel, wdat);
               end
            end
            if (waits == ack_wait) s_ack_i = s_ack_i | ecs;
            waits++;
         end
      end
      if (!done) begin
         checks++; fails++;
         $display("FAIL %s no_response: got none within 64 cycles want kind %0d", name, kind);
         void'(sb_q.pop_front());
      end
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; s_ack_i = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0;
      sel_i = '0; dat_i = '0; s_dat_i = '0; s_ack_i = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ack_o, err_o, dat_o} !== 34'h0) begin
         fails++;
         $display("FAIL reset resp: got ack=%0b err=%0b dat=%h want 0", ack_o, err_o, dat_o);
      end
      checks++;
      if ({s_cs_o, s_adr_o, s_we_o, s_sel_o, s_dat_o} !== '0) begin
         fails++;
         $display("FAIL reset chan: got cs=%b adr=%h dat=%h want 0", s_cs_o, s_adr_o, s_dat_o);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({ack_o, err_o, s_cs_o} !== '0) begin
         fails++;
         $display("FAIL post_reset idle: got ack=%0b err=%0b cs=%b want 0", ack_o, err_o, s_cs_o);
      end
   endtask

   task automatic test_read();
      xfer("read_slot0", 8'h00, 16'h0014, 1'b0, 32'h0, 4'b1111, 0, 32'hDEADBEEF,
           K_ACK, 32'hDEADBEEF, 2);
   endtask

   task automatic test_write_wait();
      xfer("write_slot1", 8'h01, 16'h0028, 1'b1, 32'h12345678, 4'b0011, 5, 32'hCAFEF00D,
           K_ACK, 32'h0, 7);
   endtask

   task automatic test_unmapped();
      xfer("unmapped_slot5", 8'h05, 16'h0004, 1'b0, 32'h0, 4'b1111, -1, 32'h0,
           K_ERR, 32'h0, 1);
      checks++;
      if ({u_ack_snap, u_err_snap, u_dat_snap} !== {1'b1, 1'b0, 32'h0}) begin
         fails++;
         $display("FAIL unmapped_ack_cfg: got ack=%0b err=%0b dat=%h want ack=1 err=0 dat=0",
                  u_ack_snap, u_err_snap, u_dat_snap);
      end
   endtask

   task automatic test_timeout();
      logic [0:23] fadr;
      fadr = 24'h01_0ABC;
      xfer("timeout_slot1", 8'h01, 16'h0ABC, 1'b0, 32'h0, 4'b1111, -1, 32'h55AA55AA,
           K_ERR, 32'h0, TO + 1);
`ifdef SPMMIO_BUS_ERRLOG_EN
      xfer("errlog_read", 8'hFF, 16'h0000, 1'b0, 32'h0, 4'b1111, -1, 32'h0,
           K_ACK, {1'b1, 1'b0, 1'b0, 5'b00000, fadr}, 1);
      xfer("errlog_clear", 8'hFF, 16'h0000, 1'b1, 32'hFFFFFFFF, 4'b1111, -1, 32'h0,
           K_ACK, 32'h0, 1);
      xfer("errlog_reread", 8'hFF, 16'h0000, 1'b0, 32'h0, 4'b1111, -1, 32'h0,
           K_ACK, {1'b0, 1'b0, 1'b0, 5'b00000, fadr}, 1);
`else
      xfer("slotFF_unmapped", 8'hFF, 16'h0000, 1'b0, 32'h0, 4'b1111, -1, 32'h0,
           K_ERR, 32'h0, 1);
`endif
   endtask

   task automatic test_abort();
      bit resp_seen;
      resp_seen = 1'b0;
      @(posedge clk); #1;
      adr_i = 24'h01_0010; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; s_ack_i = '0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         if (ack_o || err_o) resp_seen = 1'b1;
      end
      checks++;
      if (s_cs_o !== 2'b01) begin
         fails++;
         $display("FAIL abort cs_wait3: got %b want 01", s_cs_o);
      end
      cyc_i = 1'b0; stb_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (s_cs_o !== 2'b00) begin
         fails++;
         $display("FAIL abort cs_drop: got %b want 00", s_cs_o);
      end
      repeat (TO + 4) begin
         if (ack_o || err_o) resp_seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (resp_seen) begin
         fails++;
         $display("FAIL abort no_resp: got a response want none");
      end
      xfer("after_abort", 8'h00, 16'h0008, 1'b0, 32'h0, 4'b1111, 1, 32'h0BADCAFE,
           K_ACK, 32'h0BADCAFE, 3);
   endtask

   task automatic test_back_to_back();
      time t0;
      xfer("b2b_0", 8'h00, 16'h0000, 1'b0, 32'h0, 4'b1111, 0, 32'h11111111, K_ACK, 32'h11111111, 2);
      t0 = resp_t;
      xfer("b2b_1", 8'h01, 16'h0004, 1'b0, 32'h0, 4'b1111, 0, 32'h22222222, K_ACK, 32'h22222222, 2);
      checks++;
      if (resp_t - t0 !== 30) begin
         fails++;
         $display("FAIL b2b spacing: got %0t want 30 ns", resp_t - t0);
      end
      xfer("b2b_2", 8'h00, 16'h003C, 1'b1, 32'h33333333, 4'b1000, 0, 32'h44444444, K_ACK, 32'h0, 2);
   endtask

   task automatic test_reset_mid_wait();
      @(posedge clk); #1;
      adr_i = 24'h01_003C; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
      sel_i = 4'b1111; dat_i = 32'hFEEDFACE; s_ack_i = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (s_cs_o !== 2'b01) begin
         fails++;
         $display("FAIL rst_mid cs_before: got %b want 01", s_cs_o);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({ack_o, err_o, dat_o, s_cs_o, s_adr_o, s_we_o, s_sel_o, s_dat_o} !== '0) begin
         fails++;
         $display("FAIL rst_mid outputs: got cs=%b adr=%h we=%b sel=%b dat=%h want 0",
                  s_cs_o, s_adr_o, s_we_o, s_sel_o, s_dat_o);
      end
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      xfer("after_reset", 8'h00, 16'h0000, 1'b0, 32'h0, 4'b1111, 0, 32'hDEADBEEF,
           K_ACK, 32'hDEADBEEF, 2);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_wait();
      test_unmapped();
      test_timeout();
      test_abort();
      test_back_to_back();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
